biu_rsp_fifo: RTL

//  Response buffer directly upstream of the response width converter (dwc_rsp0) in the Bus Interface Unit.

---
 rtl/biu_pkg.sv | 9 +
 rtl/biu_rsp_fifo.sv | 75 +++++++
 2 files changed

// File: rtl/biu_pkg.sv
// Shared Bus Interface Unit constants and types, used by the response FIFO and width converters.
package biu_pkg;

    localparam int unsigned BIU_RSP_DATA_WIDTH = 128;
    localparam int unsigned BIU_ID_DATA_WIDTH  = 32;

    typedef logic [BIU_RSP_DATA_WIDTH-1:0] biu_rsp_data_t;

endpackage

// File: rtl/biu_rsp_fifo.sv
// First-word-fall-through response buffer between the bus side and the response width converter.
// Flags and count come only from registered pointers, so no combinational path crosses the FIFO.
module biu_rsp_fifo
    import biu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BIU_RSP_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  bus_rsp_valid,
    output logic                  bus_rsp_ready,
    input  logic [DATA_WIDTH-1:0] bus_rsp_rdata,
    output logic                  fifo_rsp_valid,
    input  logic                  fifo_rsp_ready,
    output logic [DATA_WIDTH-1:0] fifo_rsp_rdata,
    output logic [CNT_WIDTH-1:0]  fifo_count
);

    localparam int unsigned AW = CNT_WIDTH - 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic                  empty, full, push, pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign push = bus_rsp_valid & ~full;
    assign pop  = fifo_rsp_ready & ~empty;

    assign bus_rsp_ready  = ~full;
    assign fifo_rsp_valid = ~empty;
    assign fifo_rsp_rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign fifo_count     = wr_ptr_q - rd_ptr_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            // Storage is left intact; only the pointers are discarded.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = bus_rsp_rdata;
                wr_ptr_d                = wr_ptr_q + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule
